// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory and decode handshake bundle for pc_fetch_unit.
// master = fetch unit side, slave = memory / decode side.
interface pc_fetch_unit_if;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_adel;
  logic        dec_ready;

  modport master (
    output ireq_valid, ireq_addr,
    input  ireq_ready,
    input  iresp_valid, iresp_data,
    output dec_valid, dec_instr, dec_pc, dec_adel,
    input  dec_ready
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output ireq_ready,
    output iresp_valid, iresp_data,
    input  dec_valid, dec_instr, dec_pc, dec_adel,
    output dec_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch PC register, single-outstanding instruction fetch FSM and a
// one-entry decode buffer backed by a skid entry so no response is lost.
// Optional misaligned-fetch detection: define FETCH_ADEL_CHECK_EN.
//
// state  | meaning
// S_REQ  | request presented at pc, waiting for ireq_ready
// S_WAIT | request accepted, waiting for iresp_valid (drop_q discards it)
// S_HOLD | decode buffer full and a second entry parked in the skid slot
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc_new,
  input  logic        redirect,
  output logic [31:0] pc_out,
  pc_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        drop_q, drop_nxt;
  logic        dec_valid_q, dec_adel_q;
  logic [31:0] dec_instr_q, dec_pc_q;
  logic [31:0] skid_instr, skid_pc;
  logic        skid_adel;

  logic        misaligned, can_accept, ireq_valid_c;
  logic        pc_load, buf_clr, buf_load, buf_from_skid, skid_load;
  logic [31:0] ent_instr;
  logic        ent_adel;

`ifdef FETCH_ADEL_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // The buffer takes a new entry when empty or being drained this cycle.
  assign can_accept = !dec_valid_q || bus.dec_ready;

  assign pc_out         = pc;
  assign bus.ireq_addr  = pc;
  assign bus.ireq_valid = ireq_valid_c;
  assign bus.dec_valid  = dec_valid_q;
  assign bus.dec_instr  = dec_instr_q;
  assign bus.dec_pc     = dec_pc_q;
  assign bus.dec_adel   = dec_adel_q;

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_REQ;
    else         state <= state_nxt;
  end

  // Next-state decode and datapath strobes; redirect outranks everything.
  always_comb begin
    state_nxt     = state;
    drop_nxt      = drop_q;
    ireq_valid_c  = 1'b0;
    pc_load       = 1'b0;
    buf_clr       = 1'b0;
    buf_load      = 1'b0;
    buf_from_skid = 1'b0;
    skid_load     = 1'b0;
    ent_instr     = bus.iresp_data;
    ent_adel      = 1'b0;
    case (state)
      S_REQ: begin
        ireq_valid_c = !misaligned;
        if (redirect) begin
          pc_load = 1'b1;
          buf_clr = 1'b1;
          if (!misaligned && bus.ireq_ready) begin
            drop_nxt  = 1'b1;
            state_nxt = S_WAIT;
          end
        end else if (misaligned) begin
          ent_instr = 32'h0;
          ent_adel  = 1'b1;
          pc_load   = 1'b1;
          if (can_accept) begin
            buf_load = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_nxt = S_HOLD;
          end
        end else if (bus.ireq_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_load = 1'b1;
          buf_clr = 1'b1;
          if (bus.iresp_valid) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            drop_nxt  = 1'b1;
          end
        end else if (bus.iresp_valid) begin
          state_nxt = S_REQ;
          if (drop_q) begin
            drop_nxt = 1'b0;
          end else begin
            pc_load = 1'b1;
            if (can_accept) begin
              buf_load = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_nxt = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_load   = 1'b1;
          buf_clr   = 1'b1;
          state_nxt = S_REQ;
        end else if (bus.dec_ready) begin
          buf_from_skid = 1'b1;
          state_nxt     = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // PC register and wrong-path drop flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc     <= RESET_PC;
      drop_q <= 1'b0;
    end else begin
      if (pc_load) pc <= pc_new;
      drop_q <= drop_nxt;
    end
  end

  // Decode output buffer: clear on redirect, refill, or drain on handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dec_valid_q <= 1'b0;
      dec_instr_q <= 32'h0;
      dec_pc_q    <= 32'h0;
      dec_adel_q  <= 1'b0;
    end else if (buf_clr) begin
      dec_valid_q <= 1'b0;
    end else if (buf_load) begin
      dec_valid_q <= 1'b1;
      dec_instr_q <= ent_instr;
      dec_pc_q    <= pc;
      dec_adel_q  <= ent_adel;
    end else if (buf_from_skid) begin
      dec_valid_q <= 1'b1;
      dec_instr_q <= skid_instr;
      dec_pc_q    <= skid_pc;
      dec_adel_q  <= skid_adel;
    end else if (dec_valid_q && bus.dec_ready) begin
      dec_valid_q <= 1'b0;
    end
  end

  // Skid entry, only meaningful while in S_HOLD.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
      skid_adel  <= 1'b0;
    end else if (skid_load) begin
      skid_instr <= ent_instr;
      skid_pc    <= pc;
      skid_adel  <= ent_adel;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; PC selection modelled as pc+4 or redirect target.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redir_tgt = 32'h0;
  logic [31:0] pc_new;
  logic [31:0] pc_out;
  int total = 0;
  int bad = 0;

  pc_fetch_unit_if bus_if ();

  pc_fetch_unit #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .pc_new   (pc_new),
    .redirect (redirect),
    .pc_out   (pc_out),
    .bus      (bus_if)
  );

  assign pc_new = redirect ? redir_tgt : pc_out + 32'd4;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.ireq_ready  = 1'b0;
    bus_if.iresp_valid = 1'b0;
    bus_if.iresp_data  = 32'h0;
    bus_if.dec_ready   = 1'b0;

    // reset values
    tick(); tick();
    chk("rst_pc", pc_out, 32'hBFC0_0000);
    chk("rst_dec_valid", {31'h0, bus_if.dec_valid}, 32'h0);
    chk("rst_dec_instr", bus_if.dec_instr, 32'h0);
    chk("rst_dec_pc", bus_if.dec_pc, 32'h0);
    chk("rst_dec_adel", {31'h0, bus_if.dec_adel}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("rel_ireq_valid", {31'h0, bus_if.ireq_valid}, 32'h1);
    chk("rel_ireq_addr", bus_if.ireq_addr, 32'hBFC0_0000);

    // first fetch, response two cycles after acceptance
    bus_if.ireq_ready = 1'b1;
    tick();
    bus_if.ireq_ready = 1'b0;
    chk("wait_ireq_valid", {31'h0, bus_if.ireq_valid}, 32'h0);
    tick();
    chk("wait_no_dec", {31'h0, bus_if.dec_valid}, 32'h0);
    bus_if.iresp_valid = 1'b1;
    bus_if.iresp_data  = 32'h2408_0001;
    tick();
    bus_if.iresp_valid = 1'b0;
    chk("f1_dec_valid", {31'h0, bus_if.dec_valid}, 32'h1);
    chk("f1_dec_pc", bus_if.dec_pc, 32'hBFC0_0000);
    chk("f1_dec_instr", bus_if.dec_instr, 32'h2408_0001);
    chk("f1_dec_adel", {31'h0, bus_if.dec_adel}, 32'h0);
    chk("f1_pc", pc_out, 32'hBFC0_0004);
    chk("f1_ireq_valid", {31'h0, bus_if.ireq_valid}, 32'h1);

    // request held while not accepted
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_ireq_valid", {31'h0, bus_if.ireq_valid}, 32'h1);
      chk("stall_ireq_addr", bus_if.ireq_addr, 32'hBFC0_0004);
      chk("stall_dec_instr", bus_if.dec_instr, 32'h2408_0001);
    end

    // second response while buffer full -> HOLD
    bus_if.ireq_ready = 1'b1;
    tick();
    bus_if.ireq_ready = 1'b0;
    bus_if.iresp_valid = 1'b1;
    bus_if.iresp_data  = 32'h8C09_0004;
    tick();
    bus_if.iresp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_dec_valid", {31'h0, bus_if.dec_valid}, 32'h1);
      chk("hold_dec_pc", bus_if.dec_pc, 32'hBFC0_0000);
      chk("hold_dec_instr", bus_if.dec_instr, 32'h2408_0001);
      chk("hold_ireq_valid", {31'h0, bus_if.ireq_valid}, 32'h0);
      chk("hold_pc", pc_out, 32'hBFC0_0008);
      // stray response outside WAIT must be ignored
      bus_if.iresp_valid = (i == 2);
      bus_if.iresp_data  = 32'hDEAD_0000;
      tick();
      bus_if.iresp_valid = 1'b0;
    end
    chk("hold_end_instr", bus_if.dec_instr, 32'h2408_0001);
    bus_if.dec_ready = 1'b1;
    tick();
    chk("drain_dec_valid", {31'h0, bus_if.dec_valid}, 32'h1);
    chk("drain_dec_pc", bus_if.dec_pc, 32'hBFC0_0004);
    chk("drain_dec_instr", bus_if.dec_instr, 32'h8C09_0004);
    chk("drain_ireq_valid", {31'h0, bus_if.ireq_valid}, 32'h1);
    chk("drain_ireq_addr", bus_if.ireq_addr, 32'hBFC0_0008);
    tick();
    chk("empty_dec_valid", {31'h0, bus_if.dec_valid}, 32'h0);

    // redirect in WAIT: next response dropped
    bus_if.ireq_ready = 1'b1;
    tick();
    bus_if.ireq_ready = 1'b0;
    redirect  = 1'b1;
    redir_tgt = 32'hBFC0_0100;
    tick();
    redirect = 1'b0;
    chk("rw_pc", pc_out, 32'hBFC0_0100);
    chk("rw_ireq_valid", {31'h0, bus_if.ireq_valid}, 32'h0);
    bus_if.iresp_valid = 1'b1;
    bus_if.iresp_data  = 32'hDEAD_BEEF;
    tick();
    bus_if.iresp_valid = 1'b0;
    chk("rw_drop_dec_valid", {31'h0, bus_if.dec_valid}, 32'h0);
    chk("rw_ireq_valid2", {31'h0, bus_if.ireq_valid}, 32'h1);
    chk("rw_ireq_addr", bus_if.ireq_addr, 32'hBFC0_0100);

    // redirect while dec_valid=1, dec_ready=0
    bus_if.dec_ready = 1'b0;
    bus_if.ireq_ready = 1'b1;
    tick();
    bus_if.ireq_ready = 1'b0;
    bus_if.iresp_valid = 1'b1;
    bus_if.iresp_data  = 32'h1111_1111;
    tick();
    bus_if.iresp_valid = 1'b0;
    chk("rd_dec_valid", {31'h0, bus_if.dec_valid}, 32'h1);
    chk("rd_dec_pc", bus_if.dec_pc, 32'hBFC0_0100);
    redirect  = 1'b1;
    redir_tgt = 32'hBFC0_0200;
    tick();
    redirect = 1'b0;
    chk("rd_flush", {31'h0, bus_if.dec_valid}, 32'h0);
    chk("rd_ireq_valid", {31'h0, bus_if.ireq_valid}, 32'h1);
    chk("rd_ireq_addr", bus_if.ireq_addr, 32'hBFC0_0200);

    // redirect with same-cycle response in WAIT: response discarded, no drop left
    bus_if.ireq_ready = 1'b1;
    tick();
    bus_if.ireq_ready = 1'b0;
    redirect  = 1'b1;
    redir_tgt = 32'hBFC0_0300;
    bus_if.iresp_valid = 1'b1;
    bus_if.iresp_data  = 32'h2222_2222;
    tick();
    redirect = 1'b0;
    bus_if.iresp_valid = 1'b0;
    chk("rs_dec_valid", {31'h0, bus_if.dec_valid}, 32'h0);
    chk("rs_ireq_valid", {31'h0, bus_if.ireq_valid}, 32'h1);
    chk("rs_ireq_addr", bus_if.ireq_addr, 32'hBFC0_0300);
    bus_if.ireq_ready = 1'b1;
    tick();
    bus_if.ireq_ready = 1'b0;
    bus_if.iresp_valid = 1'b1;
    bus_if.iresp_data  = 32'h3333_3333;
    tick();
    bus_if.iresp_valid = 1'b0;
    chk("rs_next_valid", {31'h0, bus_if.dec_valid}, 32'h1);
    chk("rs_next_instr", bus_if.dec_instr, 32'h3333_3333);
    chk("rs_next_pc", bus_if.dec_pc, 32'hBFC0_0300);

    // redirect in REQ together with ireq_ready: response to old address dropped
    redirect  = 1'b1;
    redir_tgt = 32'hBFC0_0400;
    bus_if.ireq_ready = 1'b1;
    tick();
    redirect = 1'b0;
    bus_if.ireq_ready = 1'b0;
    chk("rr_flush", {31'h0, bus_if.dec_valid}, 32'h0);
    chk("rr_pc", pc_out, 32'hBFC0_0400);
    chk("rr_ireq_valid", {31'h0, bus_if.ireq_valid}, 32'h0);
    bus_if.iresp_valid = 1'b1;
    bus_if.iresp_data  = 32'h4444_4444;
    tick();
    bus_if.iresp_valid = 1'b0;
    chk("rr_drop", {31'h0, bus_if.dec_valid}, 32'h0);
    chk("rr_ireq_valid2", {31'h0, bus_if.ireq_valid}, 32'h1);
    chk("rr_ireq_addr", bus_if.ireq_addr, 32'hBFC0_0400);

`ifdef FETCH_ADEL_CHECK_EN
    // misaligned redirect target produces an address-error entry
    redirect  = 1'b1;
    redir_tgt = 32'hBFC0_0102;
    tick();
    redirect = 1'b0;
    chk("adel_no_req", {31'h0, bus_if.ireq_valid}, 32'h0);
    tick();
    chk("adel_dec_valid", {31'h0, bus_if.dec_valid}, 32'h1);
    chk("adel_flag", {31'h0, bus_if.dec_adel}, 32'h1);
    chk("adel_dec_pc", bus_if.dec_pc, 32'hBFC0_0102);
    chk("adel_dec_instr", bus_if.dec_instr, 32'h0);
`else
    // misaligned target fetched as-is when the check is compiled out
    redirect  = 1'b1;
    redir_tgt = 32'hBFC0_0102;
    tick();
    redirect = 1'b0;
    chk("mis_ireq_valid", {31'h0, bus_if.ireq_valid}, 32'h1);
    chk("mis_ireq_addr", bus_if.ireq_addr, 32'hBFC0_0102);
    chk("mis_dec_adel", {31'h0, bus_if.dec_adel}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'hBFC0_0000, fetch PC loaded on reset.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: pc_new  in  32  next PC from PC selection logic.
REQ-005 SHALL have port: redirect  in  1  pc_new is a taken branch/jump target; flush wrong-path work.
REQ-006 SHALL have port: pc_out  out  32  current fetch PC, fed back to PC selection for pc+4.
REQ-007 SHALL have ports: ireq_valid out 1, ireq_addr out 32, ireq_ready in 1  instruction-memory request handshake.
REQ-008 SHALL have ports: iresp_valid in 1, iresp_data in 32  instruction-memory response; no backpressure.
REQ-009 SHALL have ports: dec_valid out 1, dec_instr out 32, dec_pc out 32, dec_adel out 1, dec_ready in 1  decode handshake.

Function
REQ-010 SHALL hold the PC register pc; pc_out = pc; ireq_addr = pc.
REQ-011 SHALL implement FSM states REQ, WAIT, HOLD.
- REQ: ireq_valid=1; on ireq_ready go WAIT.
- WAIT: ireq_valid=0; on iresp_valid capture data into the output buffer, pc <= pc_new, go REQ; if the buffer cannot accept, go HOLD.
- HOLD: output buffer full with dec_ready=0; ireq_valid=0; on dec_ready go REQ.
REQ-012 SHALL allow at most one outstanding memory request.
REQ-013 SHALL drive dec_valid/dec_instr/dec_pc from a one-entry registered buffer; dec_valid rises the cycle after iresp_valid, so latency is iresp_valid to dec_valid = 1 cycle.
REQ-014 SHALL hold dec_* stable while dec_valid=1 and dec_ready=0; clear the entry on dec_valid and dec_ready unless refilled the same cycle.
REQ-015 SHALL let the buffer accept a response when it is empty or drained in the same cycle (dec_ready=1); otherwise the response is stored and the FSM enters HOLD. No response is ever lost.
REQ-016 SHALL keep ireq_valid and ireq_addr stable from assertion until ireq_ready.
REQ-017 on redirect=1 in any state SHALL set pc <= pc_new and clear the output buffer (dec_valid=0 next cycle).
- In REQ without ireq_ready: the new address is presented next cycle. This is the only permitted address change while unaccepted.
- In REQ with ireq_ready, or in WAIT: set a drop flag; the next iresp_valid is discarded, the flag clears, and the FSM goes REQ.
- In HOLD: go REQ.
REQ-018 SHALL give redirect priority over a same-cycle response. A response in WAIT with redirect=1 is discarded, and pc <= pc_new.
REQ-019 SHALL treat iresp_valid outside WAIT as a protocol error: ignore it with no state change.

Reset
REQ-020 SHALL, while resetn=0, force pc=RESET_PC, FSM=REQ, drop flag=0, dec_valid=0, dec_instr=0, dec_pc=0, dec_adel=0.
REQ-021 SHALL assert ireq_valid=1 with ireq_addr=RESET_PC in the first cycle after reset release.
REQ-022 SHALL abandon any in-flight request on reset; a response arriving after release while in REQ is ignored per REQ-019.

Configuration
REQ-023 SHALL gate misaligned-fetch detection with macro FETCH_ADEL_CHECK_EN.
- Defined: in REQ, if pc[1:0]!=0, issue no memory request (ireq_valid=0). Next cycle load the buffer with dec_instr=0, dec_pc=pc, dec_adel=1, then pc <= pc_new. Buffer-full and redirect rules apply unchanged.
- Undefined: pc[1:0] not checked, requests issued as-is, dec_adel tied 0.

Verification
REQ-024 Reset release, ireq_ready=1, response 2 cycles later with 32'h2408_0001 -> ireq_addr=32'hBFC0_0000; dec_valid=1, dec_pc=32'hBFC0_0000, dec_instr=32'h2408_0001 one cycle after iresp_valid.
REQ-025 dec_ready=0 for 5 cycles with a response buffered -> dec_* stable; FSM in HOLD; ireq_valid=0; first new request the cycle after dec_ready=1.
REQ-026 Redirect to 32'hBFC0_0100 in WAIT -> next response discarded (no dec_valid); next request address 32'hBFC0_0100.
REQ-027 Redirect while dec_valid=1, dec_ready=0 -> dec_valid=0 next cycle; request issued at the new pc.
REQ-028 ireq_ready=0 for 4 cycles -> ireq_valid and ireq_addr held constant.
REQ-029 With FETCH_ADEL_CHECK_EN, redirect to 32'hBFC0_0102 -> no ireq_valid; dec_valid=1, dec_adel=1, dec_pc=32'hBFC0_0102, dec_instr=0.
